mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage of the 5-stage RV32I pipeline, between execute and writeback.
//  Consumes ex_mem_t and drives a single-outstanding req/ack data-memory port.
//  Produces the registered mem_wb_t consumed by writeback:
//  aligned/extended load data, RVFI masks, and a carried trap.
//  Stalls upstream while a memory access is in flight.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in WAIT with no ack/err before an access fault is raised (>=1)
// PORTS
//  clk_i              in   1    clock
//  rst_i              in   1    synchronous active-high reset
//  ex_mem_pipeline_q  in   ex_mem_t  execute result: valid, mem_op, alu_csr_result (addr), store data, carried_trap, ...
//  flush_i            in   1    trap taken in WB; kill the stage contents
//  dmem_req_o         out  1    request valid; held until dmem_ack_i or dmem_err_i
//  dmem_we_o          out  1    1=store, 0=load
//  dmem_addr_o        out  32   word-aligned address ({addr[31:2],2'b00})
//  dmem_wdata_o       out  32   store data shifted to byte lane
//  dmem_wstrb_o       out  4    byte strobes (0 for loads)
//  dmem_rdata_i       in   32   load word, valid with dmem_ack_i
//  dmem_ack_i         in   1    access complete
//  dmem_err_i         in   1    bus error (access fault)
//  mem_stall_o        out  1    1 while access pending; freezes IF..EX
//  mem_wb_pipeline_q  out  mem_wb_t  registered output to writeback
// BEHAVIOUR
//  Reset: FSM=IDLE; dmem_req_o=0; dmem_we_o=0; dmem_wstrb_o=0; mem_stall_o=0.
//  Reset: mem_wb_pipeline_q='0 (valid=0, carried_trap.valid=0); timeout counter=0.
//  FSM IDLE:
//   - valid mem op, no carried trap, aligned: assert dmem_req_o combinationally.
//   - -> WAIT unless dmem_ack_i/dmem_err_i is already high (zero-wait completion).
//   - mem_stall_o = dmem_req_o & ~(ack|err).
//  FSM WAIT:
//   - hold req/addr/data/strb stable; count cycles.
//   - ack -> IDLE: capture result.
//   - err, or count==TIMEOUT_CYCLES-1 -> IDLE with access fault.
//   - ack and err in the same cycle: err wins.
//  Alignment:
//   - halfword needs addr[0]==0; word needs addr[1:0]==0.
//   - Misaligned: no request; trap cause 4 (load) / 6 (store); tval=addr.
//  Access fault: cause 5 (load) / 7 (store); tval=addr.
//  Load data: lane=addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
//   - load_rmask = lane-shifted strobe.
//  Store: wdata = rs2 << (8*addr[1:0]); wstrb = {0001,0011,1111} << addr[1:0] for SB/SH/SW.
//  Pipeline register:
//   - loads on completion, or every cycle for non-memory instructions.
//   - during stall, loads a bubble (valid=0).
//  Incoming carried_trap.valid: no memory request; trap forwarded unchanged; earliest trap wins.
//  flush_i:
//   - next mem_wb_pipeline_q.valid=0.
//   - in WAIT: drop req at the next edge and discard the late ack (return to IDLE).
//   - stores already acked are not undone.
//  Reset mid-WAIT: req drops next cycle; any outstanding ack is ignored.
// CONFIGURATION
//  RVFI_EN defined:
//   - insn, rs*_rdata, load_rmask, store_wmask, store_wdata and next_pc are carried into mem_wb_t.
//  RVFI_EN undefined:
//   - those fields are tied to 0; the architectural datapath is unchanged.
// STRUCTURE
//  params_pkg:
//   - mem_op_e (LB,LH,LW,LBU,LHU,SB,SH,SW,NONE).
//   - trap cause constants TRAP_LOAD_MISALIGNED/ACCESS, TRAP_STORE_MISALIGNED/ACCESS.
//   - ex_mem_t, mem_wb_t, trap_info_t.
//  Sub-module load_align: combinational lane select + extend + rmask (mem_op, addr[1:0], rdata).
// TESTING
//  1. LW addr 0x100, ack after 3 cycles.
//     -> stall 3 cycles; load_rdata = bus word; rmask=4'hF; no trap.
//  2. LB addr 0x103, rdata 0x80xxxxxx, zero-wait ack.
//     -> no stall; load_rdata=0xFFFFFF80.
//     Same with LBU -> 0x00000080.
//  3. SH addr 0x202, rs2=0x0000BEEF.
//     -> wstrb=4'b1100, wdata=0xBEEF0000, addr=0x200.
//  4. LW addr 0x101.
//     -> no dmem_req_o; trap valid cause 4, tval 0x101.
//     SW addr 0x102 -> trap cause 6.
//  5. SW, no ack for TIMEOUT_CYCLES.
//     -> cause 7 access fault, req drops.
//     Separately, dmem_err_i on a load -> cause 5.
//  6. flush_i in WAIT, ack one cycle later.
//     -> mem_wb valid=0, ack ignored, next instruction proceeds normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the RV32I memory-access stage: memory op encoding, trap causes,
// EX/MEM and MEM/WB pipeline register layouts, alignment and strobe helpers.
package mem_stage_pkg;

    typedef enum logic [3:0] {LB, LH, LW, LBU, LHU, SB, SH, SW, NONE} mem_op_e;

    typedef enum logic {IDLE, WAIT} mem_state_e;

    localparam logic [4:0] TRAP_LOAD_MISALIGNED  = 5'd4;
    localparam logic [4:0] TRAP_LOAD_ACCESS      = 5'd5;
    localparam logic [4:0] TRAP_STORE_MISALIGNED = 5'd6;
    localparam logic [4:0] TRAP_STORE_ACCESS     = 5'd7;

    typedef struct packed {
        logic        valid;
        logic [4:0]  cause;
        logic [31:0] tval;
    } trap_info_t;

    typedef struct packed {
        logic        valid;
        mem_op_e     mem_op;
        logic [4:0]  rd_addr;
        logic [31:0] pc;
        logic [31:0] alu_csr_result;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] insn;
        logic [31:0] next_pc;
        trap_info_t  carried_trap;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        mem_op_e     mem_op;
        logic [4:0]  rd_addr;
        logic [31:0] pc;
        logic [31:0] alu_csr_result;
        logic [31:0] load_rdata;
        trap_info_t  trap;
        logic [31:0] insn;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [3:0]  load_rmask;
        logic [3:0]  store_wmask;
        logic [31:0] store_wdata;
        logic [31:0] next_pc;
    } mem_wb_t;

    function automatic logic op_aligned(mem_op_e op, logic [1:0] lane);
        case (op)
            LH, LHU, SH: return ~lane[0];
            LW, SW:      return lane == 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(mem_op_e op, logic [1:0] lane);
        case (op)
            SB:      return 4'b0001 << lane;
            SH:      return 4'b0011 << lane;
            SW:      return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Single-outstanding req/ack data-memory port between the memory stage and the bus.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (output req, we, addr, wdata, wstrb, input rdata, ack, err);
    modport slave  (input req, we, addr, wdata, wstrb, output rdata, ack, err);
endinterface

// File: rtl/mem_stage_load_align.sv
// Load lane select and sign/zero extension, plus the byte mask actually read.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  mem_op_e     mem_op,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic [3:0]  rmask
);
    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        data    = '0;
        rmask   = '0;
        case (mem_op)
            LB:  begin data = {{24{shifted[7]}}, shifted[7:0]};   rmask = 4'b0001 << lane; end
            LBU: begin data = {24'h0, shifted[7:0]};              rmask = 4'b0001 << lane; end
            LH:  begin data = {{16{shifted[15]}}, shifted[15:0]}; rmask = 4'b0011 << lane; end
            LHU: begin data = {16'h0, shifted[15:0]};             rmask = 4'b0011 << lane; end
            LW:  begin data = shifted;                            rmask = 4'b1111;         end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives the data-memory port, aligns loads, raises
// misaligned/access-fault traps and registers mem_wb_t. RVFI_EN adds RVFI fields.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  ex_mem_t     ex_mem_pipeline_q,
    input  logic        flush_i,
    mem_stage_if.master dmem,
    output logic        mem_stall_o,
    output mem_wb_t     mem_wb_pipeline_q
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

    mem_state_e  state;
    logic [CW-1:0] cnt;
    ex_mem_t     ex;
    mem_wb_t     wb_next;
    logic [31:0] addr, wdata, align_data;
    logic [1:0]  lane;
    logic [3:0]  strb, align_rmask;
    logic        is_load, is_store, aligned, misaligned;
    logic        req, timeout, fault, done;

    assign ex = ex_mem_pipeline_q;

    // EX is frozen while stalled, so the request is driven straight from ex_mem in both states.
    always_comb begin
        addr       = ex.alu_csr_result;
        lane       = addr[1:0];
        is_load    = ex.mem_op inside {LB, LH, LW, LBU, LHU};
        is_store   = ex.mem_op inside {SB, SH, SW};
        aligned    = op_aligned(ex.mem_op, lane);
        misaligned = ex.valid & (is_load | is_store) & ~ex.carried_trap.valid & ~aligned;
        req        = ex.valid & (is_load | is_store) & ~ex.carried_trap.valid & aligned
                     & ~flush_i & ~rst_i;
        strb       = store_strobe(ex.mem_op, lane);
        wdata      = ex.rs2_rdata << {lane, 3'b000};
        timeout    = (state == WAIT) && (cnt == CW'(TIMEOUT_CYCLES - 1));
        fault      = req & (dmem.err | (timeout & ~dmem.ack));
        done       = dmem.ack | dmem.err | timeout;
    end

    assign dmem.req    = req;
    assign dmem.we     = req & is_store;
    assign dmem.addr   = {addr[31:2], 2'b00};
    assign dmem.wdata  = wdata;
    assign dmem.wstrb  = req ? strb : 4'b0000;
    assign mem_stall_o = req & ~done;

    mem_stage_load_align u_load_align (
        .mem_op (ex.mem_op),
        .lane   (lane),
        .rdata  (dmem.rdata),
        .data   (align_data),
        .rmask  (align_rmask)
    );

    always_comb begin
        wb_next                = '0;
        wb_next.valid          = ex.valid;
        wb_next.mem_op         = ex.mem_op;
        wb_next.rd_addr        = ex.rd_addr;
        wb_next.pc             = ex.pc;
        wb_next.alu_csr_result = ex.alu_csr_result;
        wb_next.load_rdata     = is_load ? align_data : '0;
        if (ex.valid && ex.carried_trap.valid) begin
            wb_next.trap = ex.carried_trap;
        end else if (misaligned || fault) begin
            wb_next.trap.valid = 1'b1;
            wb_next.trap.tval  = addr;
            if (misaligned) wb_next.trap.cause = is_load ? TRAP_LOAD_MISALIGNED : TRAP_STORE_MISALIGNED;
            else            wb_next.trap.cause = is_load ? TRAP_LOAD_ACCESS : TRAP_STORE_ACCESS;
        end
`ifdef RVFI_EN
        wb_next.insn      = ex.insn;
        wb_next.rs1_rdata = ex.rs1_rdata;
        wb_next.rs2_rdata = ex.rs2_rdata;
        wb_next.next_pc   = ex.next_pc;
        if (req && !fault) begin
            wb_next.load_rmask  = is_load  ? align_rmask : 4'b0000;
            wb_next.store_wmask = is_store ? strb : 4'b0000;
            wb_next.store_wdata = is_store ? wdata : '0;
        end
`endif
    end

`ifndef RVFI_EN
    logic unused_rvfi;
    assign unused_rvfi = ^{ex.insn, ex.rs1_rdata, ex.next_pc, align_rmask};
`endif

    // Flush/reset clear req combinationally, so WAIT sees ~req and returns to IDLE ignoring late acks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= IDLE;
            cnt               <= '0;
            mem_wb_pipeline_q <= '0;
        end else begin
            case (state)
                IDLE: if (req && !done) begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: if (!req || done) state <= IDLE;
                      else              cnt   <= cnt + CW'(1);
                default: state <= IDLE;
            endcase
            if (flush_i || mem_stall_o) mem_wb_pipeline_q <= '0;
            else                        mem_wb_pipeline_q <= wb_next;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: one task per scenario.
module tb_mem_stage;
    import mem_stage_pkg::*;

`ifdef RVFI_EN
    localparam bit RVFI = 1'b1;
`else
    localparam bit RVFI = 1'b0;
`endif

    logic    clk = 1'b0;
    logic    rst, flush, stall;
    ex_mem_t ex;
    mem_wb_t wb;
    int      errors = 0;
    int      checks = 0;

    int          st;
    bit          fin;
    logic        fr, fw;
    logic [31:0] fa, fd;
    logic [3:0]  fs;

    mem_stage_if dmem_bus();

    mem_stage #(.TIMEOUT_CYCLES(255)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ex_mem_pipeline_q (ex),
        .flush_i           (flush),
        .dmem              (dmem_bus),
        .mem_stall_o       (stall),
        .mem_wb_pipeline_q (wb)
    );

    always #5 clk = ~clk;

    task automatic set_bubble();
        ex = '0;
        ex.mem_op = NONE;
    endtask

    task automatic set_op(input mem_op_e op, input logic [31:0] a, input logic [31:0] rs2);
        ex = '0;
        ex.valid = 1'b1;
        ex.mem_op = op;
        ex.alu_csr_result = a;
        ex.rs2_rdata = rs2;
        ex.rd_addr = 5'd7;
        ex.pc = 32'h1000;
    endtask

    // Runs the op currently on ex until the stage stops stalling; starts at posedge+1.
    task automatic run_access(input int ack_at, input int err_at, output int stalls, output bit done,
                              output logic f_req, output logic f_we, output logic [31:0] f_addr,
                              output logic [31:0] f_wdata, output logic [3:0] f_wstrb);
        int cyc = 0;
        stalls = 0;
        done = 1'b0;
        while (!done && cyc < 300) begin
            dmem_bus.ack = (cyc == ack_at);
            dmem_bus.err = (cyc == err_at);
            #3;
            if (cyc == 0) begin
                f_req = dmem_bus.req; f_we = dmem_bus.we; f_addr = dmem_bus.addr;
                f_wdata = dmem_bus.wdata; f_wstrb = dmem_bus.wstrb;
            end
            if (stall) stalls++; else done = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        dmem_bus.ack = 1'b0;
        dmem_bus.err = 1'b0;
        set_bubble();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        dmem_bus.ack = 1'b0; dmem_bus.err = 1'b0; dmem_bus.rdata = '0;
        set_op(LW, 32'h100, 32'h0);
        repeat (2) @(posedge clk);
        #4;
        checks++; if (wb !== '0) begin errors++; $display("FAIL reset_wb: got %h want 0", wb); end
        checks++; if (dmem_bus.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmem_bus.req); end
        checks++; if (dmem_bus.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", dmem_bus.we); end
        checks++; if (dmem_bus.wstrb !== 4'h0) begin errors++; $display("FAIL reset_wstrb: got %h want 0", dmem_bus.wstrb); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        rst = 1'b0;
        set_bubble();
        @(posedge clk); #1;
    endtask

    task automatic test_load_wait();
        set_op(LW, 32'h100, 32'h0);
        dmem_bus.rdata = 32'h12345678;
        run_access(3, -1, st, fin, fr, fw, fa, fd, fs);
        checks++; if (st != 3) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 3", st); end
        checks++; if ({fr, fw} !== 2'b10) begin errors++; $display("FAIL lw_req_we: got %b want 10", {fr, fw}); end
        checks++; if (fa !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h want 100", fa); end
        checks++; if (fs !== 4'h0) begin errors++; $display("FAIL lw_wstrb: got %h want 0", fs); end
        checks++; if (wb.valid !== 1'b1 || wb.trap.valid !== 1'b0) begin errors++; $display("FAIL lw_valid_trap: got %b%b want 10", wb.valid, wb.trap.valid); end
        checks++; if (wb.load_rdata !== 32'h12345678) begin errors++; $display("FAIL lw_rdata: got %h want 12345678", wb.load_rdata); end
        checks++; if (wb.load_rmask !== (RVFI ? 4'hF : 4'h0)) begin errors++; $display("FAIL lw_rmask: got %h want %h", wb.load_rmask, RVFI ? 4'hF : 4'h0); end
    endtask

    task automatic test_load_byte();
        dmem_bus.rdata = 32'h80123456;
        set_op(LB, 32'h103, 32'h0);
        run_access(0, -1, st, fin, fr, fw, fa, fd, fs);
        checks++; if (st != 0) begin errors++; $display("FAIL lb_stall: got %0d want 0", st); end
        checks++; if (wb.load_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", wb.load_rdata); end
        checks++; if (wb.load_rmask !== (RVFI ? 4'h8 : 4'h0)) begin errors++; $display("FAIL lb_rmask: got %h want %h", wb.load_rmask, RVFI ? 4'h8 : 4'h0); end
        set_op(LBU, 32'h103, 32'h0);
        run_access(0, -1, st, fin, fr, fw, fa, fd, fs);
        checks++; if (wb.load_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata: got %h want 00000080", wb.load_rdata); end
        dmem_bus.rdata = 32'h8001F00F;
        set_op(LH, 32'h102, 32'h0);
        run_access(0, -1, st, fin, fr, fw, fa, fd, fs);
        checks++; if (wb.load_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_rdata: got %h want ffff8001", wb.load_rdata); end
    endtask

    task automatic test_store_half();
        set_op(SH, 32'h202, 32'h0000BEEF);
        run_access(1, -1, st, fin, fr, fw, fa, fd, fs);
        checks++; if ({fr, fw} !== 2'b11) begin errors++; $display("FAIL sh_req_we: got %b want 11", {fr, fw}); end
        checks++; if (fa !== 32'h200) begin errors++; $display("FAIL sh_addr: got %h want 200", fa); end
        checks++; if (fd !== 32'hBEEF0000) begin errors++; $display("FAIL sh_wdata: got %h want beef0000", fd); end
        checks++; if (fs !== 4'b1100) begin errors++; $display("FAIL sh_wstrb: got %b want 1100", fs); end
        checks++; if (st != 1 || wb.trap.valid !== 1'b0) begin errors++; $display("FAIL sh_done: got stall=%0d trap=%b want 1 0", st, wb.trap.valid); end
        checks++; if (wb.store_wmask !== (RVFI ? 4'hC : 4'h0)) begin errors++; $display("FAIL sh_wmask: got %h want %h", wb.store_wmask, RVFI ? 4'hC : 4'h0); end
    endtask

    task automatic test_misaligned();
        set_op(LW, 32'h101, 32'h0);
        run_access(-1, -1, st, fin, fr, fw, fa, fd, fs);
        checks++; if (fr !== 1'b0 || st != 0) begin errors++; $display("FAIL lw_mis_noreq: got req=%b stall=%0d want 0 0", fr, st); end
        checks++; if ({wb.valid, wb.trap.valid, wb.trap.cause} !== {2'b11, 5'd4}) begin errors++; $display("FAIL lw_mis_cause: got v=%b tv=%b c=%0d want 1 1 4", wb.valid, wb.trap.valid, wb.trap.cause); end
        checks++; if (wb.trap.tval !== 32'h101) begin errors++; $display("FAIL lw_mis_tval: got %h want 101", wb.trap.tval); end
        set_op(SW, 32'h102, 32'h0);
        run_access(-1, -1, st, fin, fr, fw, fa, fd, fs);
        checks++; if (fr !== 1'b0) begin errors++; $display("FAIL sw_mis_noreq: got %b want 0", fr); end
        checks++; if ({wb.trap.valid, wb.trap.cause} !== {1'b1, 5'd6}) begin errors++; $display("FAIL sw_mis_cause: got tv=%b c=%0d want 1 6", wb.trap.valid, wb.trap.cause); end
    endtask

    task automatic test_fault();
        set_op(SW, 32'h300, 32'h11);
        run_access(-1, -1, st, fin, fr, fw, fa, fd, fs);
        checks++; if (fin !== 1'b1 || st != 255) begin errors++; $display("FAIL sw_timeout_cycles: got done=%b stall=%0d want 1 255", fin, st); end
        checks++; if ({wb.trap.valid, wb.trap.cause} !== {1'b1, 5'd7}) begin errors++; $display("FAIL sw_timeout_cause: got tv=%b c=%0d want 1 7", wb.trap.valid, wb.trap.cause); end
        checks++; if (wb.trap.tval !== 32'h300) begin errors++; $display("FAIL sw_timeout_tval: got %h want 300", wb.trap.tval); end
        #3;
        checks++; if (dmem_bus.req !== 1'b0) begin errors++; $display("FAIL sw_timeout_reqdrop: got %b want 0", dmem_bus.req); end
        @(posedge clk); #1;
        set_op(LW, 32'h400, 32'h0);
        run_access(-1, 2, st, fin, fr, fw, fa, fd, fs);
        checks++; if (st != 2 || {wb.trap.valid, wb.trap.cause} !== {1'b1, 5'd5}) begin errors++; $display("FAIL lw_err: got stall=%0d tv=%b c=%0d want 2 1 5", st, wb.trap.valid, wb.trap.cause); end
        set_op(LH, 32'h402, 32'h0);
        run_access(1, 1, st, fin, fr, fw, fa, fd, fs);
        checks++; if ({wb.trap.valid, wb.trap.cause} !== {1'b1, 5'd5} || wb.trap.tval !== 32'h402) begin errors++; $display("FAIL ack_err_same: got tv=%b c=%0d tval=%h want 1 5 402", wb.trap.valid, wb.trap.cause, wb.trap.tval); end
    endtask

    task automatic test_flush();
        set_op(LW, 32'h500, 32'h0);
        #3;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_stall: got %b want 1", stall); end
        @(posedge clk); #1;
        checks++; if (wb.valid !== 1'b0 || wb.trap.valid !== 1'b0) begin errors++; $display("FAIL stall_bubble: got v=%b tv=%b want 0 0", wb.valid, wb.trap.valid); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        set_bubble();
        dmem_bus.ack = 1'b1;
        #3;
        checks++; if (dmem_bus.req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL flush_reqdrop: got req=%b stall=%b want 0 0", dmem_bus.req, stall); end
        @(posedge clk); #1;
        dmem_bus.ack = 1'b0;
        checks++; if (wb.valid !== 1'b0) begin errors++; $display("FAIL flush_wb_valid: got %b want 0", wb.valid); end
        dmem_bus.rdata = 32'hCAFEF00D;
        set_op(LW, 32'h504, 32'h0);
        run_access(1, -1, st, fin, fr, fw, fa, fd, fs);
        checks++; if (st != 1 || wb.valid !== 1'b1 || wb.load_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL post_flush_lw: got stall=%0d v=%b d=%h want 1 1 cafef00d", st, wb.valid, wb.load_rdata); end
    endtask

    task automatic test_reset_wait();
        set_op(LW, 32'h600, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_bubble();
        dmem_bus.ack = 1'b1;
        #3;
        checks++; if (dmem_bus.req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_wait_reqdrop: got req=%b stall=%b want 0 0", dmem_bus.req, stall); end
        @(posedge clk); #1;
        dmem_bus.ack = 1'b0;
        checks++; if (wb.valid !== 1'b0) begin errors++; $display("FAIL rst_wait_wb: got %b want 0", wb.valid); end
    endtask

    task automatic test_passthrough();
        set_op(LW, 32'h700, 32'h0);
        ex.carried_trap.valid = 1'b1;
        ex.carried_trap.cause = 5'd2;
        ex.carried_trap.tval  = 32'hDEAD;
        run_access(0, -1, st, fin, fr, fw, fa, fd, fs);
        checks++; if (fr !== 1'b0) begin errors++; $display("FAIL carried_noreq: got %b want 0", fr); end
        checks++; if (wb.trap !== {1'b1, 5'd2, 32'hDEAD}) begin errors++; $display("FAIL carried_trap: got %h want %h", wb.trap, {1'b1, 5'd2, 32'hDEAD}); end
        set_op(NONE, 32'h1234, 32'h0);
        run_access(-1, -1, st, fin, fr, fw, fa, fd, fs);
        checks++; if (wb.valid !== 1'b1 || wb.alu_csr_result !== 32'h1234 || wb.trap.valid !== 1'b0) begin errors++; $display("FAIL nonmem_pass: got v=%b r=%h tv=%b want 1 1234 0", wb.valid, wb.alu_csr_result, wb.trap.valid); end
        checks++; if (wb.rd_addr !== 5'd7 || wb.pc !== 32'h1000) begin errors++; $display("FAIL nonmem_fields: got rd=%0d pc=%h want 7 1000", wb.rd_addr, wb.pc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_wait();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_fault();
        test_flush();
        test_reset_wait();
        test_passthrough();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
